calc_nport_core: RTL and testbench
==================================

Name: calc_nport_core

Overview:
- Parametrised successor to the fixed 4-port CALC2 calculator core.
- NUM_PORTS request channels, each with a per-port command queue and a busy backpressure signal.
- One shared ALU, granted round-robin across ports.
- Responses return on the originating port's output lanes, tag echoed. Order is preserved within a port; ports complete out of order relative to each other.

Parameters:
- NUM_PORTS, 4, number of request/response channels (1..8)
- DATA_W, 32, operand/result width (power of 2, >=8)
- TAG_W, 2, tag width per request
- Q_DEPTH, 4, command queue entries per port (power of 2, >=2)

Ports:
- c_clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_cmd_in  in  NUM_PORTS*4  per-port command; port i at bits [4i+3:4i]
- req_data_in  in  NUM_PORTS*DATA_W  per-port operand
- req_tag_in  in  NUM_PORTS*TAG_W  per-port tag, sampled with the command
- req_busy  out  NUM_PORTS  1 = port cannot accept a new command this cycle
- out_resp  out  NUM_PORTS*2  per-port response: 0 none, 1 success, 2 overflow/underflow/invalid
- out_data  out  NUM_PORTS*DATA_W  per-port result
- out_tag  out  NUM_PORTS*TAG_W  per-port echoed tag

Behaviour:
- Reset:
  - All outputs 0.
  - Queues empty; capture state idle; round-robin pointer = port 0; ALU stage empty.
  - Reset asserted mid-operation discards captures, queued entries and in-flight results. No response is issued for discarded work.
- Request protocol, per port:
  - Cycle T: req_cmd_in != 0 while req_busy=0. Capture cmd, tag and operand1 (req_data_in).
  - Cycle T+1: operand2 is taken from req_data_in. The cmd lane is ignored in T+1.
  - Entry {cmd, tag, op1, op2} is written to the queue at the end of T+1.
  - Next command is accepted no earlier than T+2.
  - A nonzero cmd while req_busy=1 is dropped entirely: no capture, no response.
- req_busy[i]: registered; =1 when queue count + pending capture >= Q_DEPTH.
- Arbiter:
  - Each cycle, grant one non-empty queue: the first found scanning from the pointer upward with wrap.
  - The granted entry pops. The pointer moves to granted index + 1 (mod NUM_PORTS).
  - Push and pop on the same queue in one cycle are legal; count is unchanged.
- ALU (grant cycle G; result registered, visible during G+1 for exactly one cycle on the granted port's lanes; other ports show resp 0):
  - cmd 1 add: carry out of DATA_W -> resp 2, data 0; else resp 1, sum.
  - cmd 2 sub: op2 > op1 -> resp 2, data 0; else resp 1, difference.
  - cmd 5 shl: op1 << op2[log2(DATA_W)-1:0], upper op2 bits ignored, resp 1.
  - cmd 6 shr: logical right shift with the same shift-amount rule, resp 1.
  - Any other nonzero cmd: resp 2, data 0.
- Latency:
  - Minimum is command at T -> response at T+3 (write T+1, grant T+2, output T+3).
  - Throughput is one response per cycle aggregate.
- Ordering: within a port, responses follow acceptance order. Tags are not checked for uniqueness.
- Lanes not granted in a cycle drive resp 0. Their data and tag lanes drive 0.

Test Plan:
- Port0 add 0x0000_0005 + 0x0000_0003, tag 1, idle elsewhere -> 3 cycles after cmd: out_resp[0]=1, data 0x8, tag 1, one cycle only.
- Port2 add 0xFFFF_FFFF + 1 -> resp 2, data 0. Port2 sub 3 - 5 -> resp 2. Port1 cmd 3 -> resp 2.
- Port3 shl 0x1 by op2 0x0000_0024 (low 5 bits = 4) -> resp 1, data 0x10. shr 0x8000_0000 by 31 -> data 0x1.
- All four ports issue at the same cycle after reset -> responses on ports 0,1,2,3 in consecutive cycles. A second simultaneous wave is served in round-robin order continuing from port 0.
- Port0 flood: 4 back-to-back accepted commands with the ALU starved by continuous traffic on ports 1-3 -> req_busy[0]=1 once the queue is full. A 5th cmd presented while busy produces no response. The 4 accepted commands return in order.
- Reset asserted for 1 cycle with 3 entries queued and one result in flight -> all outputs 0 from the next cycle, req_busy=0, no stale responses afterwards.

Source files
------------

// File: rtl/calc_nport_core.sv
// calc_nport_core: multi-port calculator core with one shared ALU.
// Each port captures a command in two cycles (cmd/tag/op1, then op2) and
// pushes it into a per-port queue. A round-robin arbiter pops one entry per
// cycle into the ALU. The registered result appears for one cycle on the
// originating port's lanes.
// Ports:
//   c_clk, reset        clock, synchronous active-high reset
//   req_cmd_in/data/tag per-port request lanes (4 / DATA_W / TAG_W bits each)
//   req_busy            per-port backpressure (registered)
//   out_resp/data/tag   per-port response lanes (2 / DATA_W / TAG_W bits each)
module calc_nport_core #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 2,
  parameter int unsigned Q_DEPTH   = 4
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*4-1:0]        req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_data_in,
  input  logic [NUM_PORTS*TAG_W-1:0]    req_tag_in,
  output logic [NUM_PORTS-1:0]          req_busy,
  output logic [NUM_PORTS*2-1:0]        out_resp,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  output logic [NUM_PORTS*TAG_W-1:0]    out_tag
);
  localparam int unsigned PTR_W  = $clog2(Q_DEPTH);
  localparam int unsigned CNT_W  = $clog2(Q_DEPTH + 1);
  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned SH_W   = $clog2(DATA_W);

  typedef struct packed {
    logic [3:0]        cmd;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } entry_t;

  typedef enum logic {CAP_IDLE = 1'b0, CAP_OP2 = 1'b1} cap_state_t;

  cap_state_t             cap_q     [NUM_PORTS];
  cap_state_t             cap_d     [NUM_PORTS];
  logic [3:0]             cap_cmd_q [NUM_PORTS];
  logic [3:0]             cap_cmd_d [NUM_PORTS];
  logic [TAG_W-1:0]       cap_tag_q [NUM_PORTS];
  logic [TAG_W-1:0]       cap_tag_d [NUM_PORTS];
  logic [DATA_W-1:0]      cap_op1_q [NUM_PORTS];
  logic [DATA_W-1:0]      cap_op1_d [NUM_PORTS];
  entry_t                 mem_q     [NUM_PORTS][Q_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q  [NUM_PORTS];
  logic [PTR_W-1:0]       rd_ptr_d  [NUM_PORTS];
  logic [PTR_W-1:0]       wr_ptr_q  [NUM_PORTS];
  logic [PTR_W-1:0]       wr_ptr_d  [NUM_PORTS];
  logic [CNT_W-1:0]       cnt_q     [NUM_PORTS];
  logic [CNT_W-1:0]       cnt_d     [NUM_PORTS];
  logic [NUM_PORTS-1:0]   push_c;
  logic [NUM_PORTS-1:0]   pop_c;
  logic [NUM_PORTS-1:0]   busy_d;
  logic [PORT_W-1:0]      rr_q;
  logic [PORT_W-1:0]      rr_d;
  logic [PORT_W-1:0]      grant_idx_c;
  logic                   grant_vld_c;
  entry_t                 head_c;
  logic [DATA_W:0]        sum_c;
  logic [1:0]             alu_resp_c;
  logic [DATA_W-1:0]      alu_data_c;
  logic [NUM_PORTS*2-1:0]      out_resp_d;
  logic [NUM_PORTS*DATA_W-1:0] out_data_d;
  logic [NUM_PORTS*TAG_W-1:0]  out_tag_d;

  // Per-port capture FSM: cmd/tag/op1 in first cycle, op2 + push in second.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      cap_d[p]     = cap_q[p];
      cap_cmd_d[p] = cap_cmd_q[p];
      cap_tag_d[p] = cap_tag_q[p];
      cap_op1_d[p] = cap_op1_q[p];
      push_c[p]    = 1'b0;
      case (cap_q[p])
        CAP_IDLE: begin
          if (req_cmd_in[4*p +: 4] != 4'd0 && !req_busy[p]) begin
            cap_d[p]     = CAP_OP2;
            cap_cmd_d[p] = req_cmd_in[4*p +: 4];
            cap_tag_d[p] = req_tag_in[TAG_W*p +: TAG_W];
            cap_op1_d[p] = req_data_in[DATA_W*p +: DATA_W];
          end
        end
        CAP_OP2: begin
          push_c[p] = 1'b1;
          cap_d[p]  = CAP_IDLE;
        end
        default: cap_d[p] = CAP_IDLE;
      endcase
    end
  end

  // Round-robin arbiter: first non-empty queue at or after the pointer.
  always_comb begin
    int unsigned idx;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (32'(rr_q) + 32'(i)) % NUM_PORTS;
      if (!grant_vld_c && cnt_q[idx] != '0) begin
        grant_vld_c = 1'b1;
        grant_idx_c = PORT_W'(idx);
      end
    end
    rr_d = rr_q;
    if (grant_vld_c)
      rr_d = PORT_W'((32'(grant_idx_c) + 32'd1) % NUM_PORTS);
  end

  // Shared ALU on the head entry of the granted queue.
  always_comb begin
    head_c     = mem_q[grant_idx_c][rd_ptr_q[grant_idx_c]];
    sum_c      = {1'b0, head_c.op1} + {1'b0, head_c.op2};
    alu_resp_c = 2'd2;
    alu_data_c = '0;
    case (head_c.cmd)
      4'd1: if (!sum_c[DATA_W]) begin
        alu_resp_c = 2'd1;
        alu_data_c = sum_c[DATA_W-1:0];
      end
      4'd2: if (head_c.op2 <= head_c.op1) begin
        alu_resp_c = 2'd1;
        alu_data_c = head_c.op1 - head_c.op2;
      end
      4'd5: begin
        alu_resp_c = 2'd1;
        alu_data_c = head_c.op1 << head_c.op2[SH_W-1:0];
      end
      4'd6: begin
        alu_resp_c = 2'd1;
        alu_data_c = head_c.op1 >> head_c.op2[SH_W-1:0];
      end
      default: ;
    endcase
  end

  // Queue bookkeeping, busy look-ahead and response lane steering.
  always_comb begin
    out_resp_d = '0;
    out_data_d = '0;
    out_tag_d  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      pop_c[p]    = grant_vld_c && (grant_idx_c == PORT_W'(p));
      rd_ptr_d[p] = pop_c[p]  ? PTR_W'(rd_ptr_q[p] + 1'b1) : rd_ptr_q[p];
      wr_ptr_d[p] = push_c[p] ? PTR_W'(wr_ptr_q[p] + 1'b1) : wr_ptr_q[p];
      cnt_d[p]    = cnt_q[p] + CNT_W'(push_c[p]) - CNT_W'(pop_c[p]);
      // A pending capture reserves a slot so the op2 push can never overflow.
      busy_d[p]   = (32'(cnt_d[p]) + 32'(cap_d[p] == CAP_OP2)) >= Q_DEPTH;
      if (pop_c[p]) begin
        out_resp_d[2*p +: 2]           = alu_resp_c;
        out_data_d[DATA_W*p +: DATA_W] = alu_data_c;
        out_tag_d[TAG_W*p +: TAG_W]    = head_c.tag;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        cap_q[p]     <= CAP_IDLE;
        cap_cmd_q[p] <= '0;
        cap_tag_q[p] <= '0;
        cap_op1_q[p] <= '0;
        rd_ptr_q[p]  <= '0;
        wr_ptr_q[p]  <= '0;
        cnt_q[p]     <= '0;
      end
      rr_q     <= '0;
      req_busy <= '0;
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        cap_q[p]     <= cap_d[p];
        cap_cmd_q[p] <= cap_cmd_d[p];
        cap_tag_q[p] <= cap_tag_d[p];
        cap_op1_q[p] <= cap_op1_d[p];
        rd_ptr_q[p]  <= rd_ptr_d[p];
        wr_ptr_q[p]  <= wr_ptr_d[p];
        cnt_q[p]     <= cnt_d[p];
      end
      rr_q     <= rr_d;
      req_busy <= busy_d;
      out_resp <= out_resp_d;
      out_data <= out_data_d;
      out_tag  <= out_tag_d;
    end
  end

  // Queue storage; contents are don't-care while the count is zero.
  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push_c[p])
        mem_q[p][wr_ptr_q[p]] <= {cap_cmd_q[p], cap_tag_q[p], cap_op1_q[p],
                                  req_data_in[DATA_W*p +: DATA_W]};
    end
  end

endmodule

// File: tb/tb_calc_nport_core.sv
// tb_calc_nport_core: directed plus random checks of calc_nport_core against
// a queue-based behavioural model of the port/arbiter/ALU rules.
module tb_calc_nport_core;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int QD = 4;

  logic              c_clk;
  logic              reset;
  logic [NP*4-1:0]   cmd_v;
  logic [NP*DW-1:0]  data_v;
  logic [NP*TW-1:0]  tag_v;
  logic [NP-1:0]     req_busy;
  logic [NP*2-1:0]   out_resp;
  logic [NP*DW-1:0]  out_data;
  logic [NP*TW-1:0]  out_tag;

  calc_nport_core #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .Q_DEPTH(QD)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (cmd_v),
    .req_data_in (data_v),
    .req_tag_in  (tag_v),
    .req_busy    (req_busy),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .out_tag     (out_tag)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0]    cmd;
    logic [TW-1:0] tag;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
  } ent_t;

  // Reference model state
  ent_t          mq [NP][$];
  bit            pend   [NP];
  ent_t          pcap   [NP];
  bit            m_busy [NP];
  logic [1:0]    e_resp [NP];
  logic [DW-1:0] e_data [NP];
  logic [TW-1:0] e_tag  [NP];
  int            rr;

  int total = 0;
  int bad   = 0;

  function automatic void alu(input ent_t e, output logic [1:0] r, output logic [DW-1:0] d);
    longint unsigned a, b;
    a = 64'(e.op1);
    b = 64'(e.op2);
    r = 2'd2;
    d = '0;
    case (e.cmd)
      4'd1: if (a + b <= 64'hFFFF_FFFF) begin r = 2'd1; d = 32'(a + b); end
      4'd2: if (b <= a) begin r = 2'd1; d = 32'(a - b); end
      4'd5: begin r = 2'd1; d = 32'(a << (b % 32)); end
      4'd6: begin r = 2'd1; d = 32'(a >> (b % 32)); end
      default: ;
    endcase
  endfunction

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    int g;
    int p;
    ent_t e;
    logic [1:0] r;
    logic [DW-1:0] d;
    for (int i = 0; i < NP; i++) begin
      e_resp[i] = '0; e_data[i] = '0; e_tag[i] = '0;
    end
    if (reset) begin
      for (int i = 0; i < NP; i++) begin
        mq[i].delete(); pend[i] = 0; m_busy[i] = 0;
      end
      rr = 0;
      return;
    end
    g = -1;
    for (int i = 0; i < NP; i++) begin
      p = (rr + i) % NP;
      if (g < 0 && mq[p].size() > 0) g = p;
    end
    if (g >= 0) begin
      e = mq[g].pop_front();
      alu(e, r, d);
      e_resp[g] = r; e_data[g] = d; e_tag[g] = e.tag;
      rr = (g + 1) % NP;
    end
    for (int i = 0; i < NP; i++) begin
      if (pend[i]) begin
        e = pcap[i];
        e.op2 = data_v[DW*i +: DW];
        mq[i].push_back(e);
        pend[i] = 0;
      end else if (cmd_v[4*i +: 4] != 4'd0 && !m_busy[i]) begin
        pend[i] = 1;
        pcap[i].cmd = cmd_v[4*i +: 4];
        pcap[i].tag = tag_v[TW*i +: TW];
        pcap[i].op1 = data_v[DW*i +: DW];
        pcap[i].op2 = '0;
      end
    end
    for (int i = 0; i < NP; i++)
      m_busy[i] = (mq[i].size() + int'(pend[i])) >= QD;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("resp%0d", p), 64'(out_resp[2*p +: 2]), 64'(e_resp[p]));
      chk($sformatf("data%0d", p), 64'(out_data[DW*p +: DW]), 64'(e_data[p]));
      chk($sformatf("tag%0d", p), 64'(out_tag[TW*p +: TW]), 64'(e_tag[p]));
      chk($sformatf("busy%0d", p), 64'(req_busy[p]), 64'(m_busy[p]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge c_clk);
    #1;
    check_all();
  endtask

  task automatic clr();
    cmd_v = '0; data_v = '0; tag_v = '0;
  endtask

  task automatic set_port(input int p, input logic [3:0] c, input logic [DW-1:0] d,
                          input logic [TW-1:0] t);
    cmd_v[4*p +: 4] = c;
    data_v[DW*p +: DW] = d;
    tag_v[TW*p +: TW] = t;
  endtask

  task automatic issue(input int p, input logic [3:0] c, input logic [TW-1:0] t,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    clr(); set_port(p, c, a, t); tick();
    clr(); data_v[DW*p +: DW] = b; tick();
    clr();
  endtask

  logic [3:0] ctab [6];
  bit saw_busy0;
  int r;

  initial begin
    ctab = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd15};
    rr = 0;
    clr();
    reset = 1'b1;
    @(negedge c_clk);
    tick(); tick();
    chk("reset_resp", 64'(out_resp), 64'd0);
    chk("reset_busy", 64'(req_busy), 64'd0);
    reset = 1'b0;

    // Basic add with one-cycle response
    issue(0, 4'd1, 2'd1, 32'h5, 32'h3);
    tick();
    chk("add_resp", 64'(out_resp[1:0]), 64'd1);
    chk("add_data", 64'(out_data[31:0]), 64'h8);
    chk("add_tag", 64'(out_tag[1:0]), 64'd1);
    tick();
    chk("add_one_cycle", 64'(out_resp[1:0]), 64'd0);

    // Overflow, underflow, invalid
    issue(2, 4'd1, 2'd2, 32'hFFFF_FFFF, 32'h1); tick();
    chk("ovf_resp", 64'(out_resp[5:4]), 64'd2);
    chk("ovf_data", 64'(out_data[95:64]), 64'd0);
    issue(2, 4'd2, 2'd3, 32'd3, 32'd5); tick();
    chk("udf_resp", 64'(out_resp[5:4]), 64'd2);
    issue(1, 4'd3, 2'd0, 32'd7, 32'd7); tick();
    chk("inv_resp", 64'(out_resp[3:2]), 64'd2);

    // Shifts
    issue(3, 4'd5, 2'd0, 32'h1, 32'h24); tick();
    chk("shl_resp", 64'(out_resp[7:6]), 64'd1);
    chk("shl_data", 64'(out_data[127:96]), 64'h10);
    issue(3, 4'd6, 2'd1, 32'h8000_0000, 32'd31); tick();
    chk("shr_data", 64'(out_data[127:96]), 64'h1);
    clr(); repeat (3) tick();

    // Two simultaneous waves on all ports
    for (int w = 0; w < 2; w++) begin
      clr();
      for (int p = 0; p < NP; p++) set_port(p, 4'd1, 32'(p + w), 2'(p));
      tick();
      clr();
      for (int p = 0; p < NP; p++) data_v[DW*p +: DW] = 32'd10;
      tick();
      clr();
      for (int k = 0; k < NP; k++) begin
        tick();
        chk($sformatf("wave%0d_resp%0d", w, k), 64'(out_resp[2*k +: 2]), 64'd1);
        chk($sformatf("wave%0d_data%0d", w, k), 64'(out_data[DW*k +: DW]), 64'(k + w + 10));
      end
    end

    // Flood all ports; port 0 queue must fill and back-pressure
    saw_busy0 = 0;
    for (int c = 0; c < 30; c++) begin
      for (int p = 0; p < NP; p++) set_port(p, 4'd1, 32'(c), 2'(c));
      tick();
      if (req_busy[0]) saw_busy0 = 1;
    end
    chk("flood_busy0", 64'(saw_busy0), 64'd1);
    clr(); repeat (40) tick();

    // Reset with work queued and in flight
    for (int c = 0; c < 10; c++) begin
      for (int p = 0; p < NP; p++) set_port(p, 4'd2, 32'd100 + 32'(c), 2'(c));
      tick();
    end
    clr(); reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_reset_resp", 64'(out_resp), 64'd0);
    chk("mid_reset_busy", 64'(req_busy), 64'd0);
    repeat (10) tick();

    // Random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NP; p++) begin
        r = $urandom_range(0, 9);
        cmd_v[4*p +: 4] = (r < 4) ? 4'd0 : ctab[r - 4];
        data_v[DW*p +: DW] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        tag_v[TW*p +: TW] = 2'($urandom);
      end
      tick();
    end
    reset = 1'b0; clr();
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
